// File: rtl/scan_decoder_pkg.sv
// Shared constants for the scan decoder: FSM state encodings and mode values.
package scan_decoder_pkg;

  // FSM state encodings
  localparam logic [1:0] DIS    = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  // Values of the mode input
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width: clog2(dwell), never below one bit
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/scan_decoder_step_counter.sv
// Dwell/index counter for auto-scan. The index advances once every DWELL
// run cycles. wrap_out is registered on the same edge that returns the
// index from its top value to 0.
module scan_step_counter
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  output logic [SEL_W-1:0] step_out,
  output logic             wrap_out
);

  localparam int CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] dwell;
  logic             at_last;
  logic             idx_top;

  assign at_last = (dwell == LAST);
  assign idx_top = &step_out;

  // Count dwell cycles and step the index. clear wins over run, so a
  // scan (re)entry always restarts at index 0 with no wrap pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell    <= '0;
      step_out <= '0;
      wrap_out <= 1'b0;
    end else if (clear) begin
      dwell    <= '0;
      step_out <= '0;
      wrap_out <= 1'b0;
    end else if (run) begin
      wrap_out <= at_last & idx_top;
      if (at_last) begin
        dwell    <= '0;
        step_out <= step_out + 1'b1;
      end else begin
        dwell    <= dwell + 1'b1;
      end
    end else begin
      wrap_out <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Active-low 1-of-2**SEL_W decoder with three-input enable, a direct
// decode mode, and an auto-scan mode that walks every output in turn.
// All outputs are decoded from registered state, index and select.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             g1,
  input  logic             g2a_n,
  input  logic             g2b_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] dec_in,
  output logic [OUT_W-1:0] dec_out_n,
  output logic [SEL_W-1:0] sel_out,
  output logic             wrap,
  output logic             active
);

  if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
    $error("scan_decoder: SEL_W out of range 1..6");
  end
  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("scan_decoder: DWELL out of range 1..65535");
  end

  logic             en;
  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [SEL_W-1:0] dir_sel;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_wrap;
  logic             cnt_clear;
  logic             cnt_run;

  assign en = g1 & ~g2a_n & ~g2b_n;

  // Next state is re-evaluated every edge; mode matters only when enabled
  always_comb begin
    next_state = DIS;
    if (!en)                      next_state = DIS;
    else if (mode == MODE_DIRECT) next_state = DIRECT;
    else                          next_state = SCAN;
  end

  // State register and the direct-mode select sampled alongside it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= DIS;
      dir_sel <= '0;
    end else begin
      state   <= next_state;
      dir_sel <= (next_state == DIRECT) ? dec_in : '0;
    end
  end

  // Counter restarts on any cycle that is not a continuing scan
  assign cnt_run   = (state == SCAN) && (next_state == SCAN);
  assign cnt_clear = !cnt_run;

  scan_step_counter #(
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) u_step (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .run      (cnt_run),
    .step_out (scan_idx),
    .wrap_out (scan_wrap)
  );

  // Output decode from registered state: one-cold when enabled, else all ones
  always_comb begin
    sel_out   = '0;
    active    = 1'b0;
    wrap      = 1'b0;
    dec_out_n = '1;
    case (state)
      DIRECT: begin
        sel_out = dir_sel;
        active  = 1'b1;
      end
      SCAN: begin
        sel_out = scan_idx;
        active  = 1'b1;
        wrap    = scan_wrap;
      end
      default: ;
    endcase
    if (active) dec_out_n = ~(OUT_W'(1) << sel_out);
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=3, DWELL=4).
module tb_scan_decoder;

  logic       clk;
  logic       reset_n;
  logic       g1, g2a_n, g2b_n, mode;
  logic [2:0] dec_in;
  logic [7:0] dec_out_n;
  logic [2:0] sel_out;
  logic       wrap, active;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] exp_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F};

  scan_decoder #(.SEL_W(3), .DWELL(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .g1        (g1),
    .g2a_n     (g2a_n),
    .g2b_n     (g2b_n),
    .mode      (mode),
    .dec_in    (dec_in),
    .dec_out_n (dec_out_n),
    .sel_out   (sel_out),
    .wrap      (wrap),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_out,
                           input logic [2:0] e_sel, input logic e_wrap, input logic e_act);
    check({tag, ".dec_out_n"}, dec_out_n, e_out);
    check({tag, ".sel_out"}, {5'b0, sel_out}, {5'b0, e_sel});
    check({tag, ".wrap"}, {7'b0, wrap}, {7'b0, e_wrap});
    check({tag, ".active"}, {7'b0, active}, {7'b0, e_act});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    g1 = 1'b0; g2a_n = 1'b0; g2b_n = 1'b0; mode = 1'b0; dec_in = 3'd5;
    #1;
    check_all("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
    #2 reset_n = 1'b1;

    // Disabled (g1 low): all ones regardless of dec_in
    for (int c = 0; c < 10; c++) begin
      tick();
      check_all("dis", 8'hFF, 3'd0, 1'b0, 1'b0);
    end

    // Direct decode sweep, one-cycle latency
    g1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dec_in = 3'(i);
      tick();
      check_all("direct", exp_tab[i], 3'(i), 1'b0, 1'b1);
    end

    // Auto-scan from entry: each output 4 cycles, wrap once at cycle 33
    mode = 1'b1;
    dec_in = 3'd7;
    for (int c = 1; c <= 33; c++) begin
      tick();
      check_all("scan", exp_tab[((c - 1) / 4) % 8], 3'(((c - 1) / 4) % 8), (c == 33), 1'b1);
    end

    // Now at idx0 dwell0; advance to idx3 dwell2, then disable
    repeat (14) tick();
    check_all("scan.idx3", 8'hF7, 3'd3, 1'b0, 1'b1);
    g2a_n = 1'b1;
    tick();
    check_all("scan.dis", 8'hFF, 3'd0, 1'b0, 1'b0);
    g2a_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_all("scan.reentry", 8'hFE, 3'd0, 1'b0, 1'b1);
    end
    tick();
    check_all("scan.reentry.next", 8'hFD, 3'd1, 1'b0, 1'b1);

    // Now idx1 dwell0; advance to idx6 then switch to direct
    repeat (20) tick();
    check_all("scan.idx6", 8'hBF, 3'd6, 1'b0, 1'b1);
    mode = 1'b0;
    dec_in = 3'd2;
    tick();
    check_all("scan2direct", 8'hFB, 3'd2, 1'b0, 1'b1);

    // Async reset mid-scan
    mode = 1'b1;
    tick();
    check_all("scan.entry", 8'hFE, 3'd0, 1'b0, 1'b1);
    repeat (4) tick();
    check_all("scan.pre_rst", 8'hFD, 3'd1, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_all("async_rst", 8'hFF, 3'd0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    tick();
    check_all("post_rst", 8'hFE, 3'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3, width of the select index; legal range 1..6.
REQ-002 Parameter DWELL, default 4, clock cycles each output is held in scan mode; legal range 1..65535.
REQ-003 Derived constant OUT_W = 2**SEL_W, the number of active-low outputs.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 g1  input  1  enable, active-high.
REQ-007 g2a_n  input  1  enable, active-low.
REQ-008 g2b_n  input  1  enable, active-low.
REQ-009 mode  input  1  operating mode: 0 = direct decode, 1 = auto-scan.
REQ-010 dec_in  input  SEL_W  select index used in direct mode.
REQ-011 dec_out_n  output  OUT_W  registered one-cold decoder outputs.
REQ-012 sel_out  output  SEL_W  index currently driven low on dec_out_n; 0 when disabled.
REQ-013 wrap  output  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0.
REQ-014 active  output  1  high when any dec_out_n bit is low.

Function
REQ-015 The enable condition en SHALL be g1 & ~g2a_n & ~g2b_n.
REQ-016 The block SHALL implement three states: DIS, DIRECT and SCAN.
REQ-017 The next state SHALL be evaluated on every edge as follows: if en is low, DIS; else if mode is 0, DIRECT; else SCAN.
REQ-018 In DIS, dec_out_n SHALL be all ones, sel_out 0, active 0, and wrap 0.
REQ-019 In DIRECT, the value of dec_in sampled at edge k SHALL appear on dec_out_n after edge k (one-cycle latency), with only bit dec_in low.
REQ-020 On any entry into SCAN, the index and the dwell counter SHALL be cleared to 0, so bit 0 is driven low after the entry edge.
REQ-021 In SCAN, the dwell counter SHALL count from 0 to DWELL-1.
REQ-022 In SCAN, on the edge where the dwell count equals DWELL-1, the dwell counter SHALL clear and the index SHALL increment modulo OUT_W.
REQ-023 Each index SHALL therefore be held for exactly DWELL cycles.
REQ-024 When DWELL = 1, the index SHALL advance on every edge.
REQ-025 wrap SHALL be asserted for exactly one cycle, registered with the output that shows index 0 after an increment from OUT_W-1; it SHALL NOT be asserted on SCAN entry.
REQ-026 On SCAN to DIRECT, the next edge SHALL decode dec_in, and the scan index SHALL be discarded.
REQ-027 On SCAN to DIS mid-dwell, the next edge SHALL output all ones and clear the index and dwell counter.
REQ-028 A subsequent re-entry into SCAN SHALL restart at index 0.
REQ-029 dec_in SHALL be ignored in SCAN and DIS.
REQ-030 mode SHALL be ignored in DIS.
REQ-031 Exactly zero or one bit of dec_out_n SHALL be low in every cycle.
REQ-032 sel_out SHALL equal the index of the low bit of dec_out_n.
REQ-033 The dwell counter width SHALL be clog2(DWELL), with a minimum of 1.
REQ-034 The dwell counter SHALL never exceed DWELL-1.

Reset
REQ-035 While reset_n is low, state SHALL be DIS, dec_out_n all ones, sel_out 0, wrap 0, active 0, and the index and dwell counter 0, asynchronously.
REQ-036 After reset_n deasserts, the first rising edge SHALL evaluate REQ-017 normally.
REQ-037 Reset asserted mid-scan SHALL force all outputs to their reset values immediately, without waiting for a clock edge.

Structure
REQ-038 Package scan_decoder_pkg SHALL hold the state enumeration (DIS, DIRECT, SCAN) and the mode constants MODE_DIRECT = 0 and MODE_SCAN = 1.
REQ-039 Sub-module scan_step_counter SHALL hold the dwell counter and index counter, with ports clear, run, step_out and wrap_out.
REQ-040 Decode and state logic SHALL reside in scan_decoder.
REQ-041 Out-of-range parameter values SHALL be rejected at elaboration.

Verification (SEL_W=3, DWELL=4)
REQ-042 Enables 3'b000 with mode 0 and dec_in 5 for 10 cycles -> dec_out_n = 8'hFF, active 0.
REQ-043 Enables {g1,g2a_n,g2b_n} = 100, mode 0, dec_in sweeping 0..7 one per cycle -> one cycle later, dec_out_n = FE, FD, FB, F7, EF, DF, BF, 7F.
REQ-044 Enables 100 with mode 1 for 33 cycles -> each of FE..7F is held 4 cycles, wrap pulses once at cycle 33 when FE returns, and sel_out tracks the index.
REQ-045 In scan at index 3 and dwell 2, set g2a_n=1 -> next edge FF; re-enable -> FE held for 4 full cycles.
REQ-046 In scan at index 6, switch mode to 0 with dec_in = 2 -> next edge FB, with no wrap.
REQ-047 Assert reset_n low between edges during scan -> FF, sel_out 0 and wrap 0 immediately; after release with enables 100 and mode 1 -> FE after the first edge.
